// File: rtl/gearbox_20_66_pkg.sv
// gearbox_pkg: constants shared by the 20->66 RX gearbox and its 66->20 TX twin.
//   GB_LANE_W  : serial-lane word width (bits per input cycle)
//   GB_BLOCK_W : 64b/66b block width
//   GB_BUF_W   : residue + incoming word worst case (65 + 20 = 85 bits, 86 wide)
//   GB_FILL_W  : width of the residue bit counter
package gearbox_pkg;

    localparam int GB_LANE_W  = 20;
    localparam int GB_BLOCK_W = 66;
    localparam int GB_BUF_W   = 86;
    localparam int GB_FILL_W  = 7;

    // The same widths expressed at counter width, so fill/tot arithmetic
    // and compares stay width-matched.
    localparam logic [GB_FILL_W-1:0] GB_LANE_CNT  = 7'd20;
    localparam logic [GB_FILL_W-1:0] GB_BLOCK_CNT = 7'd66;

    // Mask selecting the lowest n bits of the residue buffer.
    function automatic logic [GB_BUF_W-1:0] gb_low_mask(input logic [GB_FILL_W-1:0] n);
        return (GB_BUF_W'(1) << n) - GB_BUF_W'(1);
    endfunction

endpackage

// File: rtl/gearbox_20_66_if.sv
// gearbox_20_66_if: lane-word input and block output of the RX gearbox.
//   din        : 20-bit lane word, bit 0 earliest on the wire
//   din_valid  : din accepted this cycle (no backpressure)
//   slip       : single-cycle request to drop one stream bit
//   dout       : 66-bit block, bit 0 earliest
//   dout_valid : one-cycle pulse per new block
// master = word source / block sink, slave = the gearbox.
interface gearbox_20_66_if;
    import gearbox_pkg::*;

    logic [GB_LANE_W-1:0]  din;
    logic                  din_valid;
    logic                  slip;
    logic [GB_BLOCK_W-1:0] dout;
    logic                  dout_valid;

    modport master (output din, din_valid, slip, input  dout, dout_valid);
    modport slave  (input  din, din_valid, slip, output dout, dout_valid);

endinterface

// File: rtl/gearbox_20_66.sv
// gearbox_20_66: packs a 20-bit/cycle lane stream (lsbit first) into 66-bit
// blocks for 64b/66b block lock. A slip drops the oldest un-emitted bit so
// the lock logic can walk the block boundary one bit at a time.
//   clk  : sole clock
//   sclr : synchronous active-high clear of control state and outputs
//   gb   : slave side of gearbox_20_66_if (din/din_valid/slip in,
//          dout/dout_valid out)
module gearbox_20_66
    import gearbox_pkg::*;
(
    input  logic          clk,
    input  logic          sclr,
    gearbox_20_66_if.slave gb
);

    logic [GB_BUF_W-1:0]   res_q, res_d;
    logic [GB_FILL_W-1:0]  fill_q, fill_d;
    logic                  slip_pend_q, slip_pend_d;
    logic [GB_BLOCK_W-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;

    logic [GB_BUF_W-1:0]   cat;
    logic [GB_FILL_W-1:0]  tot;

    always_comb begin
        // Stale residue above fill is masked off, so the new word lands at
        // its bit position regardless of what the buffer held there.
        cat         = res_q & gb_low_mask(fill_q);
        tot         = fill_q;
        slip_pend_d = slip_pend_q;

        if (gb.din_valid) begin
            cat = cat | ({{(GB_BUF_W-GB_LANE_W){1'b0}}, gb.din} << fill_q);
            tot = fill_q + GB_LANE_CNT;
        end

        // Drop before the emit test so a slip on a block-completing word
        // shifts that block. With nothing buffered the request waits;
        // repeats while waiting collapse into one drop.
        if (slip_pend_q || gb.slip) begin
            if (tot != '0) begin
                cat         = cat >> 1;
                tot         = tot - 7'd1;
                slip_pend_d = 1'b0;
            end else begin
                slip_pend_d = 1'b1;
            end
        end

        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        res_d        = cat;
        fill_d       = tot;
        if (tot >= GB_BLOCK_CNT) begin
            dout_d       = cat[GB_BLOCK_W-1:0];
            dout_valid_d = 1'b1;
            res_d        = cat >> GB_BLOCK_W;
            fill_d       = tot - GB_BLOCK_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            fill_q       <= '0;
            slip_pend_q  <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            fill_q       <= fill_d;
            slip_pend_q  <= slip_pend_d;
        end
    end

    // Residue data needs no clear: fill = 0 after sclr masks it all out.
    always_ff @(posedge clk) begin
        res_q <= res_d;
    end

    assign gb.dout       = dout_q;
    assign gb.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_gearbox_20_66.sv
module tb_gearbox_20_66;
    import gearbox_pkg::*;

    logic clk = 1'b0;
    logic sclr;
    always #5 clk = ~clk;

    gearbox_20_66_if gb();
    gearbox_20_66 dut (.clk(clk), .sclr(sclr), .gb(gb));

    int n_pass  = 0;
    int n_total = 0;

    // Bit-stream reference: bits still owed to the output, oldest first.
    bit          mq[$];
    logic [65:0] exp_q[$];
    bit          m_pend;
    bit          exp_vld;
    bit          mon_en;
    int          pulse_cnt;
    logic [65:0] mon_e;
    bit          out_q[$];
    logic [6:0]  prbs = 7'h7f;

    task automatic drive(input logic s_clr, input logic dv, input logic [19:0] d, input logic sl);
        @(negedge clk);
        sclr = s_clr; gb.din_valid = dv; gb.din = d; gb.slip = sl;
        exp_vld = 1'b0;
        if (s_clr) begin
            mq.delete(); exp_q.delete(); m_pend = 1'b0;
        end else begin
            if (dv) for (int i = 0; i < 20; i++) mq.push_back(d[i]);
            if (sl || m_pend) begin
                if (mq.size() > 0) begin void'(mq.pop_front()); m_pend = 1'b0; end
                else m_pend = 1'b1;
            end
            if (mq.size() >= 66) begin
                logic [65:0] b;
                for (int i = 0; i < 66; i++) b[i] = mq.pop_front();
                exp_q.push_back(b);
                exp_vld = 1'b1;
            end
        end
        @(posedge clk); #2;
    endtask

    task automatic get_word(output logic [19:0] w);
        for (int i = 0; i < 20; i++) begin
            w[i] = prbs[6] ^ prbs[5];
            prbs = {prbs[5:0], w[i]};
        end
    endtask

    task automatic collect();
        if (gb.dout_valid === 1'b1) for (int i = 0; i < 66; i++) out_q.push_back(gb.dout[i]);
    endtask

    // Scoreboard: every cycle the valid pulse must match the reference, and
    // each block must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            n_total++;
            if (gb.dout_valid !== exp_vld)
                $display("FAIL sb_valid: dout_valid=%b required=%b t=%0t", gb.dout_valid, exp_vld, $time);
            else n_pass++;
            if (gb.dout_valid === 1'b1) begin
                pulse_cnt++;
                n_total++;
                if (exp_q.size() == 0) $display("FAIL sb_block: unexpected block %h", gb.dout);
                else begin
                    mon_e = exp_q.pop_front();
                    if (gb.dout !== mon_e) $display("FAIL sb_block: dout=%h required=%h", gb.dout, mon_e);
                    else n_pass++;
                end
            end
        end
    end

    task automatic test_reset();
        drive(1, 0, 20'h0, 0);
        drive(1, 1, 20'hABCDE, 1);
        n_total++; if (gb.dout !== 66'd0) $display("FAIL rst_dout: %h required 0", gb.dout); else n_pass++;
        n_total++; if (gb.dout_valid !== 1'b0) $display("FAIL rst_vld: %b required 0", gb.dout_valid); else n_pass++;
        n_total++; if (dut.fill_q !== 7'd0) $display("FAIL rst_fill: %0d required 0", dut.fill_q); else n_pass++;
        n_total++; if (dut.slip_pend_q !== 1'b0) $display("FAIL rst_pend: %b required 0", dut.slip_pend_q); else n_pass++;
        mon_en = 1'b1;
    endtask

    task automatic test_prbs();
        int ft[10] = '{20, 40, 60, 14, 34, 54, 8, 28, 48, 2};
        bit stream[$];
        logic [19:0] w;
        int p0, nbad;
        drive(1, 0, 20'h0, 0);
        out_q.delete(); p0 = pulse_cnt;
        for (int k = 0; k < 33; k++) begin
            get_word(w);
            for (int i = 0; i < 20; i++) stream.push_back(w[i]);
            drive(0, 1, w, 0);
            collect();
            if (k < 10) begin
                n_total++;
                if (dut.fill_q !== 7'(ft[k])) $display("FAIL prbs_fill: word %0d fill=%0d required=%0d", k, dut.fill_q, ft[k]);
                else n_pass++;
            end
            if (k <= 3) begin
                n_total++;
                if (gb.dout_valid !== (k == 3)) $display("FAIL prbs_first: word %0d dout_valid=%b required=%b", k, gb.dout_valid, k == 3);
                else n_pass++;
            end
        end
        n_total++; if (pulse_cnt - p0 != 10) $display("FAIL prbs_pulses: %0d required 10", pulse_cnt - p0); else n_pass++;
        nbad = 0;
        for (int i = 0; i < out_q.size() && i < stream.size(); i++) if (out_q[i] != stream[i]) nbad++;
        n_total++;
        if (out_q.size() != 660 || nbad != 0) $display("FAIL prbs_stream: %0d bits out, %0d wrong, required 660 bits 0 wrong", out_q.size(), nbad);
        else n_pass++;
    endtask

    task automatic test_slip_idle();
        logic [79:0] s;
        logic [19:0] w;
        drive(1, 0, 20'h0, 0);
        drive(0, 0, 20'h0, 1);
        n_total++; if (dut.slip_pend_q !== 1'b1) $display("FAIL idle_pend: %b required 1", dut.slip_pend_q); else n_pass++;
        n_total++; if (dut.fill_q !== 7'd0) $display("FAIL idle_fill0: %0d required 0", dut.fill_q); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            get_word(w); s[k*20 +: 20] = w;
            drive(0, 1, w, 0);
        end
        n_total++; if (gb.dout_valid !== 1'b1 || gb.dout !== s[66:1]) $display("FAIL idle_block: vld=%b dout=%h required %h", gb.dout_valid, gb.dout, s[66:1]); else n_pass++;
        n_total++; if (dut.fill_q !== 7'd13) $display("FAIL idle_fill: %0d required 13", dut.fill_q); else n_pass++;
        n_total++; if (dut.slip_pend_q !== 1'b0) $display("FAIL idle_pend_clr: %b required 0", dut.slip_pend_q); else n_pass++;
    endtask

    task automatic test_slip_emit();
        logic [79:0] s;
        logic [19:0] w;
        drive(1, 0, 20'h0, 0);
        for (int k = 0; k < 4; k++) begin
            get_word(w); s[k*20 +: 20] = w;
            drive(0, 1, w, k == 3);
        end
        n_total++; if (gb.dout_valid !== 1'b1 || gb.dout !== s[66:1]) $display("FAIL emit_block: vld=%b dout=%h required %h", gb.dout_valid, gb.dout, s[66:1]); else n_pass++;
        n_total++; if (dut.fill_q !== 7'd13) $display("FAIL emit_fill: %0d required 13", dut.fill_q); else n_pass++;
    endtask

    task automatic test_toggle();
        bit stream[$];
        logic [19:0] w;
        int p0, nbad;
        drive(1, 0, 20'h0, 0);
        out_q.delete(); p0 = pulse_cnt;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                get_word(w);
                for (int b = 0; b < 20; b++) stream.push_back(w[b]);
                drive(0, 1, w, 0);
            end else begin
                drive(0, 0, 20'($urandom), 0);
                n_total++; if (gb.dout_valid !== 1'b0) $display("FAIL tog_idle: cycle %0d dout_valid=%b required 0", i, gb.dout_valid); else n_pass++;
            end
            collect();
        end
        n_total++; if (pulse_cnt - p0 != 3) $display("FAIL tog_pulses: %0d required 3", pulse_cnt - p0); else n_pass++;
        n_total++; if (dut.fill_q !== 7'd2) $display("FAIL tog_fill: %0d required 2", dut.fill_q); else n_pass++;
        nbad = 0;
        for (int i = 0; i < out_q.size(); i++) if (out_q[i] != stream[i]) nbad++;
        n_total++;
        if (out_q.size() != 198 || nbad != 0) $display("FAIL tog_stream: %0d bits out, %0d wrong, required 198 bits 0 wrong", out_q.size(), nbad);
        else n_pass++;
    endtask

    task automatic test_sclr_mid();
        logic [79:0] s;
        logic [19:0] w;
        drive(1, 0, 20'h0, 0);
        for (int k = 0; k < 6; k++) begin get_word(w); drive(0, 1, w, 0); end
        n_total++; if (dut.fill_q !== 7'd54) $display("FAIL mid_fill54: %0d required 54", dut.fill_q); else n_pass++;
        drive(1, 1, 20'($urandom), 1);
        n_total++; if (gb.dout_valid !== 1'b0) $display("FAIL mid_vld: %b required 0", gb.dout_valid); else n_pass++;
        n_total++; if (dut.fill_q !== 7'd0) $display("FAIL mid_fill0: %0d required 0", dut.fill_q); else n_pass++;
        n_total++; if (dut.slip_pend_q !== 1'b0) $display("FAIL mid_pend: %b required 0", dut.slip_pend_q); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            get_word(w); s[k*20 +: 20] = w;
            drive(0, 1, w, 0);
        end
        n_total++; if (gb.dout_valid !== 1'b1 || gb.dout !== s[65:0]) $display("FAIL mid_block: vld=%b dout=%h required %h", gb.dout_valid, gb.dout, s[65:0]); else n_pass++;
        n_total++; if (dut.fill_q !== 7'd14) $display("FAIL mid_fill14: %0d required 14", dut.fill_q); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit stream[$];
        logic [19:0] w;
        int p0, nbad;
        drive(1, 0, 20'h0, 0);
        out_q.delete(); p0 = pulse_cnt;
        for (int k = 0; k < 12; k++) begin
            get_word(w);
            for (int b = 0; b < 20; b++) stream.push_back(w[b]);
            drive(0, 1, w, k >= 4 && k <= 6);
            collect();
        end
        // First block took bits 0..65, so the three slips remove 66, 67, 68.
        for (int i = 0; i < 3; i++) stream.delete(66);
        nbad = 0;
        for (int i = 0; i < out_q.size(); i++) if (out_q[i] != stream[i]) nbad++;
        n_total++;
        if (out_q.size() != 198 || nbad != 0) $display("FAIL b2b_stream: %0d bits out, %0d wrong, required 198 bits 0 wrong", out_q.size(), nbad);
        else n_pass++;
        n_total++; if (pulse_cnt - p0 != 3) $display("FAIL b2b_pulses: %0d required 3", pulse_cnt - p0); else n_pass++;
        n_total++; if (dut.fill_q !== 7'd39) $display("FAIL b2b_fill: %0d required 39", dut.fill_q); else n_pass++;
    endtask

    task automatic test_lock();
        bit tx[$];
        logic [19:0] w;
        int slips, good;
        logic sl;
        drive(1, 0, 20'h0, 0);
        for (int i = 0; i < 37; i++) tx.push_back(1'($urandom));
        slips = 0; good = 0; sl = 1'b0;
        for (int n = 0; n < 3000 && good < 64; n++) begin
            if (tx.size() < 20) begin
                tx.push_back(1'b1); tx.push_back(1'b0);
                for (int i = 0; i < 64; i++) tx.push_back(1'($urandom));
            end
            for (int i = 0; i < 20; i++) w[i] = tx.pop_front();
            drive(0, 1, w, sl);
            sl = 1'b0;
            if (gb.dout_valid === 1'b1) begin
                if (gb.dout[1:0] == 2'b01 || gb.dout[1:0] == 2'b10) good++;
                else begin good = 0; sl = 1'b1; slips++; end
            end
        end
        n_total++; if (good < 64) $display("FAIL lock_reached: run=%0d required 64", good); else n_pass++;
        n_total++; if (slips > 66) $display("FAIL lock_slips: %0d required <= 66", slips); else n_pass++;
    endtask

    initial begin
        sclr = 1'b1; gb.din = '0; gb.din_valid = 1'b0; gb.slip = 1'b0;
        mon_en = 1'b0; pulse_cnt = 0; exp_vld = 1'b0; m_pend = 1'b0;
        test_reset();
        test_prbs();
        test_slip_idle();
        test_slip_emit();
        test_toggle();
        test_sclr_mid();
        test_back_to_back();
        test_lock();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gearbox_20_66.md
# gearbox_20_66

Receive-side gearbox that packs a 20-bit-per-cycle serial-lane word stream (lsbit first) into 66-bit blocks. It sits between the transceiver RX parallel interface and the 64b/66b block-lock and descrambler logic. It mirrors the transmit-side 66→20 gearbox. A `slip` input discards one bit of stream alignment so block-lock logic can hunt for the sync header.

## Interface
- Parameters: none. Widths are fixed at 20 in, 66 out; constants come from the shared package.
- `clk`  in  1  sole clock.
- `sclr`  in  1  synchronous, active-high reset. Clears control state and outputs.
- `din`  in  20  lane word; bit 0 is earliest on the wire.
- `din_valid`  in  1  `din` is accepted this cycle. No backpressure; the block always accepts.
- `slip`  in  1  single-cycle request to drop one stream bit.
- `dout`  out  66  assembled block; bit 0 is the earliest bit.
- `dout_valid`  out  1  `dout` holds a new block this cycle (one-cycle pulse per block).

## Operation
- State:
  - `buf[85:0]` holds residue bits.
  - `fill[6:0]` counts valid residue bits, range 0..65 between cycles.
  - `slip_pend` is a single-bit flag.
- Per cycle, build `cat` and `tot`:
  - `cat[fill-1:0] = buf[fill-1:0]`.
  - If `din_valid`: `cat[fill+19:fill] = din`, `tot = fill+20`; otherwise `tot = fill`.
  - Bits of `cat` above `tot` are don't-care. They must never reach `dout`.
  - Insertion is positional, not an OR, so `buf` data need not be cleared.
- Slip handling:
  - `s = slip_pend | slip`.
  - If `s` and `tot ≥ 1`: `cat = cat >> 1`, `tot = tot - 1`, clear `slip_pend`.
  - If `s` and `tot == 0`: set `slip_pend`. The slip is applied on the next cycle with `tot ≥ 1`.
  - Multiple requests while one is pending coalesce into a single slip. At most one bit is dropped per cycle.
- Emit:
  - If `tot ≥ 66`: `dout <= cat[65:0]`, `dout_valid <= 1`, `buf <= cat >> 66`, `fill <= tot - 66`.
  - Otherwise: `dout_valid <= 0`, `dout` holds its value, `buf <= cat`, `fill <= tot`.
- Width bound: `tot ≤ 85`, so the `cat`/`buf` width is 86. The `fill ≤ 65` invariant holds after every update.
- Steady state with continuous `din_valid`: 10 blocks per 33 input words. The `fill` sequence after reset is 20, 40, 60, 14, 34, 54, 8, 28, 48, 2, …; the pattern repeats every 33 words.
- A slip delays subsequent block boundaries by one bit. Data order is otherwise preserved exactly.

## Timing
- Latency: the word completing a block is accepted at edge N; `dout`/`dout_valid` are registered and visible after edge N (one register stage).
- Reset values: `dout = 0`, `dout_valid = 0`, `fill = 0`, `slip_pend = 0`. `buf` contents are don't-care.
- `sclr` dominates all inputs that cycle: `din`, `din_valid` and `slip` are discarded. The first post-reset bit is `din[0]` of the next valid cycle.
- `sclr` mid-block: the partial residue is lost and no partial block is emitted.
- Slip in the same cycle as an emitting word: drop one bit first, then evaluate `tot ≥ 66`.
- Slip with `din_valid = 0` and `fill > 0`: the drop is applied immediately to `buf` bit 0.
- `dout_valid` is never high on two consecutive cycles in steady state, but the design must not rely on this.

## Structure
- Shared package `gearbox_pkg` holds:
  - `GB_LANE_W = 20`, `GB_BLOCK_W = 66`, `GB_BUF_W = 86`, `GB_FILL_W = 7`.
  - Both 66↔20 gearboxes import it.
- Single module; no sub-module is warranted. The insert/shift datapath is one combinational block feeding the registers.

## Test plan
- Reset, then `din_valid = 1` with a 660-bit known PRBS over 33 words. Expect:
  - First `dout_valid` after the 4th word.
  - Exactly 10 pulses.
  - Concatenated `dout` equals the input stream bit-for-bit.
- Loopback from `gearbox_66_20` sending blocks `{sync 2'b01, 64'hx}`. Assert `slip` once per mismatching block until `dout[1:0]` is `01`/`10` for 64 consecutive blocks. Lock must be reached within 66 slips.
- Single slip with `din_valid = 0` right after reset (`fill = 0`). Expect:
  - `slip_pend = 1`.
  - The next 4 valid words yield a first `dout` equal to stream bits 1..66.
  - `fill = 13` afterwards.
- `din_valid` toggling 1-0-1-0 over a 200-bit stream. Output equals the input, with no `dout_valid` on invalid-only cycles except residue ≥ 66, which cannot occur.
- `sclr` asserted when `fill = 54` with `slip` high in the same cycle. Expect:
  - `dout_valid = 0`, `fill = 0` next cycle, `slip_pend = 0`.
  - The first block after reset consists of the post-reset words only.
- Back-to-back slips on 3 consecutive cycles with valid data. Exactly 3 bits are dropped: the output equals the input with bits k, k+1, k+2 of the merged stream removed.
